dac_seq: RTL
============

# dac_seq

Multi-channel DAC refresh sequencer for the serial quad DAC on the board, replacing the single-channel DAC driver. On each `sample_tick` it snapshots up to four 12-bit channel values and transmits one 32-bit SPI frame per enabled channel, in ascending channel order. It sits between the waveform generators and the DAC pins and owns the SPI bus, `dac_cs` and `dac_clr`.

## Interface
- `CHANNELS`, 4 — number of channels; legal range 1..4.
- `DATA_W`, 12 — bits per channel sample.
- `CLK_DIV`, 1 — SCK half-period, in `clk` cycles; minimum 1.
- `CS_GAP`, 2 — `clk` cycles `dac_cs` stays high between frames; minimum 1.
- `COMMAND`, 4'b0011 — command nibble used for channel frames (write and update).
- `clk` in 1 — system clock.
- `rst` in 1 — asynchronous reset, active-high.
- `sample_tick` in 1 — one-cycle request to start a sweep.
- `ch_en` in `CHANNELS` — channel enable mask; sampled together with `sample_tick`.
- `data` in `CHANNELS*DATA_W` — packed samples; channel i occupies `data[i*DATA_W +: DATA_W]`.
- `spi_mosi` out 1 — serial data, MSB first.
- `spi_sck` out 1 — serial clock; idles low.
- `dac_cs` out 1 — chip select, active-low.
- `dac_clr` out 1 — DAC clear, equal to `!rst`.
- `busy` out 1 — a sweep is in progress.
- `done` out 1 — one-cycle pulse at the end of a sweep.
- `overrun` out 1 — one-cycle pulse when `sample_tick` arrives while `busy`.

## Operation
- Frame layout, 32 bits, MSB first: {8'd0, command[3:0], addr[3:0], sample[11:0], 4'd0}. Channel i uses `addr` = i.
- Samples narrower than 12 bits are left-aligned and zero-padded.
- FSM states:
  - IDLE: waits for `sample_tick`.
  - SHIFT: sends one frame.
  - GAP: inter-frame chip-select-high period.
  - UPDATE: present only under the macro below.
- IDLE, `sample_tick`=1 with `ch_en`≠0:
  - registers `data` and `ch_en` into snapshot registers;
  - loads the lowest enabled channel;
  - goes to SHIFT.
- IDLE, `sample_tick`=1 with `ch_en`=0: no frame is sent; `done` pulses on the next cycle.
- SHIFT to GAP after 32 bits.
- GAP, after `CS_GAP` cycles:
  - goes to SHIFT with the next-higher enabled channel, if one exists;
  - otherwise goes to IDLE and pulses `done`.
- Changes to `data` or `ch_en` during a sweep do not affect it.
- `sample_tick` while `busy`: ignored, `overrun` pulses the same cycle. A tick on the same cycle as `done` counts as busy.
- Reset values:
  - `dac_cs`=1, `spi_sck`=0, `spi_mosi`=0;
  - `busy`=0, `done`=0, `overrun`=0;
  - `dac_clr`=0 while `rst` is high;
  - FSM in IDLE, snapshot registers cleared.
- Reset mid-frame aborts the frame immediately (asynchronously). The frame is discarded and is not resumed.

## Timing
- `sample_tick` sampled at edge t0. From t0+1: `dac_cs`=0, `busy`=1, and `spi_mosi` carries bit 31.
- Each bit lasts 2·`CLK_DIV` cycles:
  - `spi_sck` low for the first `CLK_DIV` cycles, high for the second `CLK_DIV`;
  - `spi_mosi` changes only while `spi_sck` is low, on the cycle SCK falls or CS falls;
  - the DAC samples on the rising edge of `spi_sck`.
- `dac_cs` stays low for exactly 64·`CLK_DIV` cycles, then high for `CS_GAP` cycles.
- Sweep length with N enabled channels is N·(64·`CLK_DIV`+`CS_GAP`) cycles. `done` pulses in the following cycle, and `busy` falls in that same cycle.
- `spi_mosi`=0 whenever `dac_cs`=1.

## Configuration
- Macro: `DAC_SEQ_SYNC_UPDATE_EN`.
- Defined:
  - channel frames use command 4'b0000 (write input register only);
  - after the last channel GAP, the FSM enters UPDATE and sends one extra frame {8'd0, 4'b0001, 4'b1111, 16'd0} (update all), followed by `CS_GAP`;
  - all outputs change simultaneously;
  - sweep length becomes (N+1)·(64·`CLK_DIV`+`CS_GAP`);
  - with `ch_en`=0, no frame is sent at all.
- Undefined: the `COMMAND` parameter is used per channel, and the UPDATE state does not exist.

## Structure
- Package `dac_seq_pkg` holds:
  - `FRAME_W`=32;
  - command codes: `CMD_WRITE`=0000, `CMD_UPDATE`=0001, `CMD_WRITE_UPDATE`=0011;
  - `ADDR_ALL`=1111;
  - the FSM state encoding.
- Sub-module `dac_spi_shifter`:
  - 32-bit load-and-shift register, SCK divider and bit counter;
  - handshake: `load` pulse in, `frame_done` pulse out;
  - it owns `spi_sck`, `spi_mosi` and `dac_cs`.
- The top level holds the FSM, the snapshot registers, the channel priority selection and the status pulses.

## Test plan
- `CLK_DIV`=1, `CS_GAP`=2, `ch_en`=4'b1111, data A..D = 12'h123/456/789/ABC, one tick:
  - four frames 0x00301230, 0x00314560, 0x00327890, 0x0033ABC0;
  - each frame 64 cycles with `dac_cs` low;
  - `done` pulses at t0+265.
- `ch_en`=4'b0101: only channels 0 and 2 are sent; `done` pulses at t0+133.
- Second tick during sweep, then `data` changed mid-sweep:
  - `overrun` pulses once;
  - no extra sweep starts;
  - transmitted values equal the snapshot taken at t0.
- `ch_en`=0: no `dac_cs` activity; `done` pulses at t0+1; `busy` never rises.
- `rst` asserted in the middle of bit 17:
  - `dac_cs`=1, `spi_sck`=0, `spi_mosi`=0 asynchronously, `dac_clr`=0;
  - a tick after release starts a clean frame from bit 31.
- `DAC_SEQ_SYNC_UPDATE_EN`, `ch_en`=4'b0011:
  - frames 0x000xxxx0 and 0x001xxxx0, then 0x001F0000;
  - `done` pulses after the third GAP.

Source files
------------

// File: rtl/dac_seq_pkg.sv
// rtl/dac_seq_pkg.sv - frame constants, command codes, FSM encoding and frame builder for dac_seq
// DAC_SEQ_SYNC_UPDATE_EN adds the UPDATE state to the encoding.
package dac_seq_pkg;

    localparam int FRAME_W = 32;

    localparam logic [3:0] CMD_WRITE        = 4'b0000;
    localparam logic [3:0] CMD_UPDATE       = 4'b0001;
    localparam logic [3:0] CMD_WRITE_UPDATE = 4'b0011;
    localparam logic [3:0] ADDR_ALL         = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_GAP    = 2'd2
`ifdef DAC_SEQ_SYNC_UPDATE_EN
        , ST_UPDATE = 2'd3
`endif
    } state_e;

    function automatic logic [FRAME_W-1:0] make_frame(
        input logic [3:0]  cmd,
        input logic [3:0]  addr,
        input logic [11:0] sample
    );
        return {8'd0, cmd, addr, sample, 4'd0};
    endfunction

endpackage

// File: rtl/dac_spi_shifter.sv
// rtl/dac_spi_shifter.sv - 32-bit load-and-shift SPI transmitter with SCK divider; owns sck/mosi/cs
module dac_spi_shifter
    import dac_seq_pkg::*;
#(
    parameter int CLK_DIV = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               load,
    input  logic [FRAME_W-1:0] frame,
    output logic               frame_done,
    output logic               spi_sck,
    output logic               spi_mosi,
    output logic               dac_cs
);

    localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

    logic               active_q, active_d;
    logic               sck_q, sck_d;
    logic [FRAME_W-1:0] sreg_q, sreg_d;
    logic [4:0]         bit_q, bit_d;
    logic [15:0]        div_q, div_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active_q <= 1'b0;
            sck_q    <= 1'b0;
            sreg_q   <= '0;
            bit_q    <= '0;
            div_q    <= '0;
        end else begin
            active_q <= active_d;
            sck_q    <= sck_d;
            sreg_q   <= sreg_d;
            bit_q    <= bit_d;
            div_q    <= div_d;
        end
    end

    always_comb begin
        active_d   = active_q;
        sck_d      = sck_q;
        sreg_d     = sreg_q;
        bit_d      = bit_q;
        div_d      = div_q;
        frame_done = 1'b0;
        if (load) begin
            active_d = 1'b1;
            sck_d    = 1'b0;
            sreg_d   = frame;
            bit_d    = 5'd31;
            div_d    = '0;
        end else if (active_q) begin
            if (div_q == DIV_LAST) begin
                div_d = '0;
                if (!sck_q) begin
                    sck_d = 1'b1;
                end else begin
                    // Falling SCK ends the bit; data advances only here so MOSI is stable while SCK is high.
                    sck_d = 1'b0;
                    if (bit_q == 5'd0) begin
                        active_d   = 1'b0;
                        frame_done = 1'b1;
                    end else begin
                        bit_d  = bit_q - 5'd1;
                        sreg_d = {sreg_q[FRAME_W-2:0], 1'b0};
                    end
                end
            end else begin
                div_d = div_q + 16'd1;
            end
        end
    end

    assign spi_sck  = sck_q;
    assign spi_mosi = active_q & sreg_q[FRAME_W-1];
    assign dac_cs   = ~active_q;

endmodule

// File: rtl/dac_seq.sv
// rtl/dac_seq.sv - multi-channel DAC refresh sequencer: snapshots channels on sample_tick, sends one SPI frame each
// DAC_SEQ_SYNC_UPDATE_EN: write-only channel frames followed by one broadcast update frame.
module dac_seq
    import dac_seq_pkg::*;
#(
    parameter int         CHANNELS = 4,
    parameter int         DATA_W   = 12,
    parameter int         CLK_DIV  = 1,
    parameter int         CS_GAP   = 2,
    parameter logic [3:0] COMMAND  = CMD_WRITE_UPDATE
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         sample_tick,
    input  logic [CHANNELS-1:0]          ch_en,
    input  logic [CHANNELS*DATA_W-1:0]   data,
    output logic                         spi_mosi,
    output logic                         spi_sck,
    output logic                         dac_cs,
    output logic                         dac_clr,
    output logic                         busy,
    output logic                         done,
    output logic                         overrun
);

`ifdef DAC_SEQ_SYNC_UPDATE_EN
    localparam logic [3:0] CH_CMD = CMD_WRITE;
`else
    localparam logic [3:0] CH_CMD = COMMAND;
`endif
    localparam int          PAD      = 12 - DATA_W;
    localparam logic [15:0] GAP_LAST = 16'(CS_GAP - 1);

    state_e                       state_q, state_d;
    logic [CHANNELS*DATA_W-1:0]   data_q, data_d;
    logic [CHANNELS-1:0]          en_q, en_d;
    logic [1:0]                   cur_q, cur_d;
    logic [15:0]                  gap_q, gap_d;
    logic                         done_q, done_d;

    logic                         load;
    logic                         frame_done;
    logic [FRAME_W-1:0]           frame;
    logic [1:0]                   first_ch, nxt_ch, load_ch;
    logic                         nxt_found;
    logic [CHANNELS*DATA_W-1:0]   src_data;
    logic [DATA_W-1:0]            sample;
    logic [11:0]                  sample12;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            en_q    <= '0;
            cur_q   <= '0;
            gap_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            en_q    <= en_d;
            cur_q   <= cur_d;
            gap_q   <= gap_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        en_d    = en_q;
        cur_d   = cur_q;
        gap_d   = gap_q;
        done_d  = 1'b0;
        load    = 1'b0;

        first_ch = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (ch_en[i]) first_ch = 2'(i);
        end
        nxt_found = 1'b0;
        nxt_ch    = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (en_q[i] && (i > int'(cur_q))) begin
                nxt_found = 1'b1;
                nxt_ch    = 2'(i);
            end
        end

        // The first frame loads on the tick edge itself, so it is built from the live inputs.
        load_ch  = (state_q == ST_IDLE) ? first_ch : nxt_ch;
        src_data = (state_q == ST_IDLE) ? data : data_q;
        sample   = src_data[int'(load_ch)*DATA_W +: DATA_W];
        sample12 = 12'(sample) << PAD;
        frame    = make_frame(CH_CMD, {2'b00, load_ch}, sample12);

        case (state_q)
            ST_IDLE: begin
                if (sample_tick && !done_q) begin
                    if (|ch_en) begin
                        data_d  = data;
                        en_d    = ch_en;
                        cur_d   = first_ch;
                        load    = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
                        done_d = 1'b1;
                    end
                end
            end
            ST_SHIFT: begin
                if (frame_done) begin
                    state_d = ST_GAP;
                    gap_d   = '0;
                end
            end
            ST_GAP: begin
                if (gap_q == GAP_LAST) begin
                    if (nxt_found) begin
                        cur_d   = nxt_ch;
                        load    = 1'b1;
                        state_d = ST_SHIFT;
                    end else begin
`ifdef DAC_SEQ_SYNC_UPDATE_EN
                        frame   = make_frame(CMD_UPDATE, ADDR_ALL, 12'd0);
                        load    = 1'b1;
                        gap_d   = '0;
                        state_d = ST_UPDATE;
`else
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
`ifdef DAC_SEQ_SYNC_UPDATE_EN
            ST_UPDATE: begin
                // Covers both the update frame and its trailing gap; the gap count starts once CS is high.
                if (!dac_cs) begin
                    gap_d = '0;
                end else if (gap_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end else begin
                    gap_d = gap_q + 16'd1;
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    dac_spi_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .frame      (frame),
        .frame_done (frame_done),
        .spi_sck    (spi_sck),
        .spi_mosi   (spi_mosi),
        .dac_cs     (dac_cs)
    );

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign overrun = sample_tick & (busy | done_q);
    assign dac_clr = ~rst;

endmodule
